// File: rtl/inst_loader_pkg.sv
// Shared instruction-path constants and loader state type.
// Memory width/depth and timing values live here so loader and memory agree.
package inst_loader_pkg;

   localparam int INST_WIDTH    = 36;
   localparam int IM_ADDR_WIDTH = 8;
   localparam int EXEC_DELAY    = 18;
   localparam int OUT_LAT       = 2;

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_BURST = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

endpackage

// File: rtl/inst_loader_prog_buf.sv
// Program staging buffer: simple dual-port RAM with synchronous write and
// a registered synchronous read port.
module prog_buf
   import inst_loader_pkg::*;
#(
   parameter int WIDTH = INST_WIDTH,
   parameter int DEPTH = 2**IM_ADDR_WIDTH
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/inst_loader.sv
// Stages a host program, replays it to the instruction memory as one
// gap-free burst, then holds off the next program until execution ends.
module inst_loader #(
   parameter int INST_WIDTH = inst_loader_pkg::INST_WIDTH,
   parameter int DEPTH      = 2**inst_loader_pkg::IM_ADDR_WIDTH,
   parameter int EXEC_DELAY = inst_loader_pkg::EXEC_DELAY,
   parameter int OUT_LAT    = inst_loader_pkg::OUT_LAT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [INST_WIDTH-1:0]    s_data,
   input  logic                     s_last,
   output logic                     inst_in_v,
   output logic [INST_WIDTH-1:0]    inst_in,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   prog_len
);
   import inst_loader_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + EXEC_DELAY + OUT_LAT + 1);

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr;
   logic [AW:0]     rd_cnt;
   logic [CW-1:0]   wait_cnt;
   logic            rd_v;
   logic [INST_WIDTH-1:0] rd_data;

   logic wr_en, fill_last, rd_en, burst_end, wait_end;

   always_comb begin
      state_d   = state_q;
      s_ready   = 1'b0;
      wr_en     = 1'b0;
      fill_last = 1'b0;
      rd_en     = 1'b0;
      burst_end = 1'b0;
      wait_end  = 1'b0;
      case (state_q)
         S_FILL: begin
            s_ready   = 1'b1;
            wr_en     = s_valid;
            fill_last = s_valid && (s_last || wr_ptr == AW'(DEPTH - 1));
            if (fill_last) state_d = S_BURST;
         end
         S_BURST: begin
            rd_en = (rd_cnt < prog_len);
            // last read data is in flight when every address has been issued
            burst_end = rd_v && (rd_cnt == prog_len);
            if (burst_end) state_d = S_WAIT;
         end
         S_WAIT: begin
            wait_end = (wait_cnt == '0);
            if (wait_end) state_d = S_FILL;
         end
         default: state_d = S_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FILL;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_cnt    <= '0;
         rd_v      <= 1'b0;
         wait_cnt  <= '0;
         prog_len  <= '0;
         inst_in_v <= 1'b0;
         inst_in   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done      <= 1'b0;
         rd_v      <= rd_en;
         inst_in_v <= rd_v;
         inst_in   <= rd_v ? rd_data : '0;
         if (rd_v) busy <= 1'b1;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (fill_last) begin
            prog_len <= {1'b0, wr_ptr} + 1'b1;
            rd_cnt   <= '0;
         end
         if (rd_en) rd_cnt <= rd_cnt + 1'b1;
         // WAIT spans L execution cycles plus the pipeline guard
         if (burst_end) wait_cnt <= CW'(prog_len) + CW'(EXEC_DELAY + OUT_LAT - 1);
         if (state_q == S_WAIT) begin
            if (wait_end) begin
               done   <= 1'b1;
               busy   <= 1'b0;
               wr_ptr <= '0;
            end else begin
               wait_cnt <= wait_cnt - 1'b1;
            end
         end
      end
   end

   prog_buf #(
      .WIDTH (INST_WIDTH),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (s_data),
      .rd_en   (rd_en),
      .rd_addr (rd_cnt[AW-1:0]),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader with a behavioural instruction-memory model
// on the burst side; one task per scenario.
module tb_inst_loader;
   import inst_loader_pkg::*;

   localparam int W     = INST_WIDTH;
   localparam int D     = 2**IM_ADDR_WIDTH;
   localparam int GUARD = EXEC_DELAY + OUT_LAT;

   logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, s_last = 1'b0;
   logic [W-1:0] s_data = '0;
   logic s_ready, inst_in_v, busy, done;
   logic [W-1:0] inst_in;
   logic [$clog2(D):0] prog_len;

   always #5 clk = ~clk;

   inst_loader #(
      .INST_WIDTH (W),
      .DEPTH      (D),
      .EXEC_DELAY (EXEC_DELAY),
      .OUT_LAT    (OUT_LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .inst_in_v (inst_in_v),
      .inst_in   (inst_in),
      .busy      (busy),
      .done      (done),
      .prog_len  (prog_len)
   );

   int vectors = 0, miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [W-1:0] pw [D+16];
   logic [W-1:0] beat_q[$];
   int           beat_cyc[$];
   int           done_cyc[$];
   logic         done_busy[$], done_rdy[$];
   logic [W-1:0] out_q[$];
   int           out_cyc[$];

   // instruction memory model: write counter reset by gaps, pc starts EXEC_DELAY after first beat
   logic [W-1:0] im_mem [D];
   int im_wcnt = 0, im_len = 0, im_dly = 0, im_pc = -1;
   bit           im_ov [OUT_LAT];
   logic [W-1:0] im_od [OUT_LAT];

   always @(negedge clk) begin
      if (inst_in_v) begin beat_q.push_back(inst_in); beat_cyc.push_back(cyc); end
      if (done) begin
         done_cyc.push_back(cyc); done_busy.push_back(busy); done_rdy.push_back(s_ready);
      end
      if (im_ov[OUT_LAT-1]) begin out_q.push_back(im_od[OUT_LAT-1]); out_cyc.push_back(cyc); end
      for (int k = OUT_LAT - 1; k > 0; k--) begin im_ov[k] = im_ov[k-1]; im_od[k] = im_od[k-1]; end
      im_ov[0] = 1'b0;
      if (im_pc >= 0) begin
         im_ov[0] = 1'b1; im_od[0] = im_mem[im_pc % D]; im_pc++;
         if (im_pc >= im_len) im_pc = -1;
      end
      if (im_dly > 0) begin im_dly--; if (im_dly == 0) im_pc = 0; end
      if (inst_in_v) begin
         if (im_wcnt == 0) im_dly = EXEC_DELAY;
         im_mem[im_wcnt % D] = inst_in; im_wcnt++; im_len = im_wcnt;
      end else im_wcnt = 0;
   end

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic clear_q();
      beat_q.delete(); beat_cyc.delete(); done_cyc.delete();
      done_busy.delete(); done_rdy.delete(); out_q.delete(); out_cyc.delete();
   endtask

   task automatic host_word(input logic [W-1:0] d, input logic l, output int hcyc);
      bit ok = 0;
      hcyc = -1;
      s_valid = 1'b1; s_data = d; s_last = l;
      for (int i = 0; i < 4000 && !ok; i++) begin
         if (s_ready) begin ok = 1; tick(); hcyc = cyc; end
         else tick();
      end
      s_valid = 1'b0; s_last = 1'b0;
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL host_handshake got=timeout want=accept"); end
   endtask

   task automatic send_prog(input int off, input int n, input logic use_last,
                            input bit gaps, output int hlast);
      int h;
      hlast = -1;
      for (int i = 0; i < n; i++) begin
         host_word(pw[off+i], use_last && (i == n - 1), h);
         hlast = h;
         if (gaps && i != n - 1) tick();
      end
   endtask

   task automatic wait_done(input int n, input int budget);
      int i = 0;
      while (done_cyc.size() < n && i < budget) begin tick(); i++; end
      vectors++;
      if (done_cyc.size() < n) begin
         miscompares++; $display("FAIL done_wait got=%0d want=%0d", done_cyc.size(), n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b0;
      repeat (3) tick();
      vectors += 6;
      if (s_ready !== 1'b1)  begin miscompares++; $display("FAIL rst_s_ready got=%b want=1", s_ready); end
      if (inst_in_v !== 1'b0) begin miscompares++; $display("FAIL rst_inst_in_v got=%b want=0", inst_in_v); end
      if (inst_in !== '0)    begin miscompares++; $display("FAIL rst_inst_in got=%h want=0", inst_in); end
      if (busy !== 1'b0)     begin miscompares++; $display("FAIL rst_busy got=%b want=0", busy); end
      if (done !== 1'b0)     begin miscompares++; $display("FAIL rst_done got=%b want=0", done); end
      if (prog_len !== '0)   begin miscompares++; $display("FAIL rst_prog_len got=%0d want=0", prog_len); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic(input bit gaps);
      int h;
      clear_q();
      pw[0] = 36'hA; pw[1] = 36'hB; pw[2] = 36'hC; pw[3] = 36'hD;
      send_prog(0, 4, 1'b1, gaps, h);
      vectors++;
      if (prog_len !== 9'd4) begin miscompares++; $display("FAIL basic_prog_len gaps=%0d got=%0d want=4", gaps, prog_len); end
      wait_done(1, 200);
      vectors++;
      if (beat_q.size() != 4) begin miscompares++; $display("FAIL basic_beats gaps=%0d got=%0d want=4", gaps, beat_q.size()); end
      for (int i = 0; i < 4 && i < beat_q.size(); i++) begin
         vectors += 2;
         if (beat_q[i] !== pw[i]) begin miscompares++; $display("FAIL basic_word%0d got=%h want=%h", i, beat_q[i], pw[i]); end
         if (beat_cyc[i] != h + 2 + i) begin miscompares++; $display("FAIL basic_beat_cyc%0d got=%0d want=%0d", i, beat_cyc[i], h + 2 + i); end
      end
      if (done_cyc.size() > 0) begin
         vectors++;
         if (done_cyc[0] != h + 5 + 4 + GUARD) begin
            miscompares++; $display("FAIL basic_done_cyc got=%0d want=%0d", done_cyc[0], h + 5 + 4 + GUARD);
         end
      end
   endtask

   task automatic test_single();
      int h;
      clear_q();
      pw[0] = 36'h123;
      send_prog(0, 1, 1'b1, 1'b0, h);
      wait_done(1, 100);
      vectors += 2;
      if (beat_q.size() != 1) begin miscompares++; $display("FAIL single_beats got=%0d want=1", beat_q.size()); end
      if (prog_len !== 9'd1) begin miscompares++; $display("FAIL single_prog_len got=%0d want=1", prog_len); end
      if (beat_q.size() > 0 && done_cyc.size() > 0) begin
         vectors += 5;
         if (beat_q[0] !== 36'h123) begin miscompares++; $display("FAIL single_word got=%h want=123", beat_q[0]); end
         if (beat_cyc[0] != h + 2) begin miscompares++; $display("FAIL single_beat_cyc got=%0d want=%0d", beat_cyc[0], h + 2); end
         if (done_cyc[0] != beat_cyc[0] + 21) begin miscompares++; $display("FAIL single_done_cyc got=%0d want=%0d", done_cyc[0], beat_cyc[0] + 21); end
         if (done_busy[0] !== 1'b0) begin miscompares++; $display("FAIL single_done_busy got=%b want=0", done_busy[0]); end
         if (done_rdy[0] !== 1'b1) begin miscompares++; $display("FAIL single_done_ready got=%b want=1", done_rdy[0]); end
      end
   endtask

   task automatic test_overflow();
      int h, h2, errs;
      clear_q();
      for (int i = 0; i < D; i++) pw[i] = 36'h5_0000_0000 + 36'(i * 7);
      pw[D] = 36'hF_EEE0_0001;
      send_prog(0, D, 1'b0, 1'b0, h);
      vectors += 2;
      if (prog_len !== 9'(D)) begin miscompares++; $display("FAIL ovf_prog_len got=%0d want=%0d", prog_len, D); end
      if (s_ready !== 1'b0) begin miscompares++; $display("FAIL ovf_s_ready got=%b want=0", s_ready); end
      host_word(pw[D], 1'b1, h2);
      vectors += 2;
      if (done_cyc.size() != 1) begin miscompares++; $display("FAIL ovf_done_count got=%0d want=1", done_cyc.size()); end
      else if (h2 != done_cyc[0] + 1) begin miscompares++; $display("FAIL ovf_stall got=%0d want=%0d", h2, done_cyc[0] + 1); end
      if (done_cyc.size() > 0 && done_cyc[0] != h + 2 + D - 1 + D + GUARD) begin
         miscompares++; $display("FAIL ovf_done_cyc got=%0d want=%0d", done_cyc[0], h + 2 + D - 1 + D + GUARD);
      end
      wait_done(2, 100);
      vectors += 2;
      if (beat_q.size() != D + 1) begin miscompares++; $display("FAIL ovf_beats got=%0d want=%0d", beat_q.size(), D + 1); end
      errs = 0;
      for (int i = 0; i < D && i < beat_q.size(); i++)
         if (beat_q[i] !== pw[i] || beat_cyc[i] != h + 2 + i) errs++;
      if (errs != 0) begin miscompares++; $display("FAIL ovf_burst got=%0d_bad_beats want=0", errs); end
      if (beat_q.size() == D + 1) begin
         vectors++;
         if (beat_q[D] !== pw[D]) begin miscompares++; $display("FAIL ovf_next_word got=%h want=%h", beat_q[D], pw[D]); end
      end
   endtask

   task automatic test_reset_mid();
      int h, i;
      clear_q();
      for (int k = 0; k < 10; k++) pw[k] = 36'h0_0000_0100 + 36'(k);
      send_prog(0, 10, 1'b1, 1'b0, h);
      i = 0;
      while (beat_q.size() < 3 && i < 50) begin tick(); i++; end
      rst = 1'b1;
      tick();
      vectors += 3;
      if (inst_in_v !== 1'b0) begin miscompares++; $display("FAIL abort_inst_in_v got=%b want=0", inst_in_v); end
      if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got=%b want=0", busy); end
      if (s_ready !== 1'b1) begin miscompares++; $display("FAIL abort_s_ready got=%b want=1", s_ready); end
      rst = 1'b0;
      clear_q();
      pw[0] = 36'h55; pw[1] = 36'h66;
      send_prog(0, 2, 1'b1, 1'b0, h);
      wait_done(1, 100);
      repeat (30) tick();
      vectors += 3;
      if (beat_q.size() != 2) begin miscompares++; $display("FAIL abort_new_beats got=%0d want=2", beat_q.size()); end
      else if (beat_q[0] !== 36'h55 || beat_q[1] !== 36'h66 || beat_cyc[0] != h + 2 || beat_cyc[1] != h + 3) begin
         miscompares++; $display("FAIL abort_new_words got=%h,%h want=55,66", beat_q[0], beat_q[1]);
      end
      if (done_cyc.size() != 1) begin miscompares++; $display("FAIL abort_done_count got=%0d want=1", done_cyc.size()); end
   endtask

   task automatic test_back_to_back();
      int h;
      clear_q();
      for (int k = 0; k < 10; k++) pw[k] = 36'h7_0000_0000 + 36'(k * 16 + 3);
      send_prog(0, 5, 1'b1, 1'b0, h);
      send_prog(5, 5, 1'b1, 1'b0, h);
      wait_done(2, 400);
      repeat (5) tick();
      vectors++;
      if (out_q.size() != 10) begin miscompares++; $display("FAIL b2b_out_count got=%0d want=10", out_q.size()); end
      for (int i = 0; i < 10 && i < out_q.size(); i++) begin
         vectors++;
         if (out_q[i] !== pw[i]) begin miscompares++; $display("FAIL b2b_out%0d got=%h want=%h", i, out_q[i], pw[i]); end
      end
      if (out_q.size() == 10 && done_cyc.size() == 2) begin
         vectors += 2;
         if (done_cyc[0] <= out_cyc[4]) begin miscompares++; $display("FAIL b2b_done0_order got=%0d want>%0d", done_cyc[0], out_cyc[4]); end
         if (done_cyc[1] <= out_cyc[9]) begin miscompares++; $display("FAIL b2b_done1_order got=%0d want>%0d", done_cyc[1], out_cyc[9]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic(1'b0);
      test_basic(1'b1);
      test_single();
      test_overflow();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog");
   end

endmodule
